// File: rtl/rule_id_packer_16_256_if.sv
// Rule-ID stream in (16-bit beats) and packed flit stream out (256-bit), with handshakes.
// slave = packer side; master = the surrounding producer/consumer side.
interface rule_id_packer_16_256_if;
  logic         in_rule_sop;
  logic         in_rule_eop;
  logic         in_rule_valid;
  logic [15:0]  in_rule_data;
  logic         in_rule_ready;
  logic         out_rule_sop;
  logic         out_rule_eop;
  logic         out_rule_valid;
  logic [255:0] out_rule_data;
  logic [4:0]   out_rule_empty;
  logic         out_rule_ready;

  modport slave (
    input  in_rule_sop, in_rule_eop, in_rule_valid, in_rule_data,
    output in_rule_ready,
    output out_rule_sop, out_rule_eop, out_rule_valid, out_rule_data, out_rule_empty,
    input  out_rule_ready
  );

  modport master (
    output in_rule_sop, in_rule_eop, in_rule_valid, in_rule_data,
    input  in_rule_ready,
    input  out_rule_sop, out_rule_eop, out_rule_valid, out_rule_data, out_rule_empty,
    output out_rule_ready
  );
endinterface

// File: rtl/rule_id_packer_16_256.sv
// Packs 16-bit matched rule IDs 16-per-flit into 256-bit framed flits behind one output register.
// Optional RULE_PKT_STATS_EN adds packet / rule-ID counters.
module rule_id_packer_16_256 (
  input  logic clk,
  input  logic rst,
  rule_id_packer_16_256_if.slave bus,
  output logic proto_err
`ifdef RULE_PKT_STATS_EN
  ,
  output logic [31:0] stat_pkt_cnt,
  output logic [31:0] stat_rule_cnt
`endif
);

  logic [3:0]   cnt;
  logic [255:0] acc;
  logic [255:0] merged;
  logic         first_flit;
  logic         emit;
  logic         accept;
  logic         xfer;

  // Unused bytes left when the last written lane is 'last_lane' (two bytes per lane).
  function automatic logic [4:0] empty_bytes(input logic [3:0] last_lane);
    return {4'd15 - last_lane, 1'b0};
  endfunction

  assign emit           = (cnt == 4'd15) | bus.in_rule_eop;
  assign bus.in_rule_ready = !emit | !bus.out_rule_valid | bus.out_rule_ready;
  assign accept         = bus.in_rule_valid & bus.in_rule_ready;
  assign xfer           = bus.out_rule_valid & bus.out_rule_ready;

  // Lanes above cnt are always zero in acc, so overlaying the current beat gives the flit.
  always_comb begin
    merged = acc;
    merged[{cnt, 4'b0000} +: 16] = bus.in_rule_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt                <= 4'd0;
      acc                <= '0;
      first_flit         <= 1'b1;
      proto_err          <= 1'b0;
      bus.out_rule_valid <= 1'b0;
      bus.out_rule_sop   <= 1'b0;
      bus.out_rule_eop   <= 1'b0;
      bus.out_rule_data  <= '0;
      bus.out_rule_empty <= 5'd0;
    end else begin
      if (xfer)
        bus.out_rule_valid <= 1'b0;
      if (accept) begin
        if (emit) begin
          bus.out_rule_data  <= merged;
          bus.out_rule_valid <= 1'b1;
          bus.out_rule_sop   <= first_flit;
          bus.out_rule_eop   <= bus.in_rule_eop;
          bus.out_rule_empty <= bus.in_rule_eop ? empty_bytes(cnt) : 5'd0;
          cnt                <= 4'd0;
          acc                <= '0;
          first_flit         <= bus.in_rule_eop;
        end else begin
          acc[{cnt, 4'b0000} +: 16] <= bus.in_rule_data;
          cnt                       <= cnt + 4'd1;
        end
        if (bus.in_rule_sop && (!first_flit || cnt != 4'd0))
          proto_err <= 1'b1;
      end
    end
  end

`ifdef RULE_PKT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkt_cnt  <= 32'd0;
      stat_rule_cnt <= 32'd0;
    end else begin
      if (xfer && bus.out_rule_eop)
        stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
      if (accept)
        stat_rule_cnt <= stat_rule_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rule_id_packer_16_256.sv
// Bench for rule_id_packer_16_256: per-scenario tasks against a packet-to-flit reference model.
module tb_rule_id_packer_16_256;
  typedef struct packed {
    logic         sop;
    logic         eop;
    logic [4:0]   empty;
    logic [255:0] data;
  } flit_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rule_id_packer_16_256_if bus();
  logic proto_err;
`ifdef RULE_PKT_STATS_EN
  logic [31:0] stat_pkt_cnt;
  logic [31:0] stat_rule_cnt;
`endif

  rule_id_packer_16_256 dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .proto_err(proto_err)
`ifdef RULE_PKT_STATS_EN
    ,
    .stat_pkt_cnt(stat_pkt_cnt),
    .stat_rule_cnt(stat_rule_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  flit_t exp_q[$];
  flit_t got_q[$];
  logic [15:0] pkt[$];

  logic bp_rand = 1'b0;
  logic rdy_val = 1'b1;
  logic rdy = 1'b1;
  assign bus.out_rule_ready = rdy;

  always @(posedge clk) begin
    #2;
    rdy = bp_rand ? 1'($urandom_range(0, 1)) : rdy_val;
  end

  always @(negedge clk)
    if (!rst && bus.out_rule_valid && bus.out_rule_ready)
      got_q.push_back(flit_t'({bus.out_rule_sop, bus.out_rule_eop, bus.out_rule_empty, bus.out_rule_data}));

  // Reference: a packet of N IDs becomes ceil(N/16) flits, lanes filled in order.
  task automatic model_packet();
    int n;
    n = pkt.size();
    for (int b = 0; b < n; b += 16) begin
      flit_t f;
      int k;
      f = '0;
      k = (n - b > 16) ? 16 : n - b;
      for (int j = 0; j < k; j++) f.data[j*16 +: 16] = pkt[b+j];
      f.sop   = (b == 0);
      f.eop   = (b + 16 >= n);
      f.empty = f.eop ? 5'(2 * (16 - k)) : 5'd0;
      exp_q.push_back(f);
    end
  endtask

  task automatic send_beat(input logic s, input logic e, input logic [15:0] d, output int cyc);
    logic acc;
    bus.in_rule_sop   = s;
    bus.in_rule_eop   = e;
    bus.in_rule_data  = d;
    bus.in_rule_valid = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      acc = bus.in_rule_ready;
      @(posedge clk);
      #1;
      cyc++;
    end while (!acc && cyc < 200);
    bus.in_rule_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL beat_accept_timeout: data=%h not accepted after %0d cycles", d, cyc);
    end
  endtask

  task automatic send_packet(input int extra_sop_idx);
    int cyc;
    for (int i = 0; i < pkt.size(); i++)
      send_beat(i == 0 || i == extra_sop_idx, i == pkt.size() - 1, pkt[i], cyc);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (got_q.size() < exp_q.size() && t < 500) begin
      @(posedge clk); #1; t++;
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_rule_valid = 1'b0; bus.in_rule_sop = 1'b0; bus.in_rule_eop = 1'b0; bus.in_rule_data = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.out_rule_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.out_rule_valid); end
    checks++; if (bus.out_rule_sop !== 1'b0) begin errors++; $display("FAIL reset_sop: got %b want 0", bus.out_rule_sop); end
    checks++; if (bus.out_rule_eop !== 1'b0) begin errors++; $display("FAIL reset_eop: got %b want 0", bus.out_rule_eop); end
    checks++; if (bus.out_rule_data !== 256'd0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.out_rule_data); end
    checks++; if (bus.out_rule_empty !== 5'd0) begin errors++; $display("FAIL reset_empty: got %0d want 0", bus.out_rule_empty); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
    checks++; if (bus.in_rule_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_rule_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    exp_q.delete(); got_q.delete();
    pkt = '{16'h00A5};
    model_packet();
    send_packet(-1);
    wait_drain();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL single_count: got %0d flits want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL single_flit %0d: got sop=%b eop=%b empty=%0d data=%h want sop=%b eop=%b empty=%0d data=%h", i,
                 got_q[i].sop, got_q[i].eop, got_q[i].empty, got_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].empty, exp_q[i].data);
      end
    end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0].empty !== 5'd30) begin errors++; $display("FAIL single_empty: got %0d want 30", got_q[0].empty); end
    end
  endtask

  task automatic test_full_and_split();
    exp_q.delete(); got_q.delete();
    pkt.delete();
    for (int i = 1; i <= 16; i++) pkt.push_back(16'(i));
    model_packet();
    send_packet(-1);
    pkt.delete();
    for (int i = 0; i < 20; i++) pkt.push_back(16'h0100 + 16'(i));
    model_packet();
    send_packet(-1);
    wait_drain();
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL full_split_count: got %0d flits want 3", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL full_split_flit %0d: got sop=%b eop=%b empty=%0d data=%h want sop=%b eop=%b empty=%0d data=%h", i,
                 got_q[i].sop, got_q[i].eop, got_q[i].empty, got_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].empty, exp_q[i].data);
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    int stalls;
    exp_q.delete(); got_q.delete();
    rdy_val = 1'b0;
    @(posedge clk); #1;
    pkt.delete();
    for (int i = 0; i < 32; i++) pkt.push_back(16'h0200 + 16'(i));
    model_packet();
    for (int i = 0; i < 16; i++) send_beat(i == 0, 1'b0, pkt[i], cyc);
    stalls = 0;
    for (int i = 16; i < 31; i++) begin
      send_beat(1'b0, 1'b0, pkt[i], cyc);
      if (cyc != 1) stalls++;
    end
    checks++; if (stalls != 0) begin errors++; $display("FAIL bp_accumulate: got %0d stalled beats want 0", stalls); end
    bus.in_rule_sop = 1'b0; bus.in_rule_eop = 1'b1; bus.in_rule_data = pkt[31]; bus.in_rule_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.in_rule_ready !== 1'b0 || bus.out_rule_valid !== 1'b1 || bus.out_rule_data !== exp_q[0].data) begin errors++;
        $display("FAIL bp_hold cycle %0d: got in_ready=%b out_valid=%b data=%h want in_ready=0 out_valid=1 data=%h",
                 c, bus.in_rule_ready, bus.out_rule_valid, bus.out_rule_data, exp_q[0].data);
      end
    end
    @(posedge clk); #1;
    rdy_val = 1'b1;
    send_beat(1'b0, 1'b1, pkt[31], cyc);
    wait_drain();
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL bp_count: got %0d flits want 2", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL bp_flit %0d: got sop=%b eop=%b empty=%0d data=%h want sop=%b eop=%b empty=%0d data=%h", i,
                 got_q[i].sop, got_q[i].eop, got_q[i].empty, got_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].empty, exp_q[i].data);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    int cyc;
    exp_q.delete(); got_q.delete();
    for (int i = 0; i < 7; i++) send_beat(i == 0, 1'b0, 16'hBEE0 + 16'(i), cyc);
    pulse_reset();
    checks++; if (bus.out_rule_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", bus.out_rule_valid); end
    pkt = '{16'h1234};
    model_packet();
    send_packet(-1);
    wait_drain();
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL rst_mid_count: got %0d flits want 1", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL rst_mid_flit %0d: got sop=%b eop=%b empty=%0d data=%h want sop=%b eop=%b empty=%0d data=%h", i,
                 got_q[i].sop, got_q[i].eop, got_q[i].empty, got_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].empty, exp_q[i].data);
      end
    end
  endtask

  task automatic test_proto_err();
    int cyc;
    exp_q.delete(); got_q.delete();
    pkt = '{16'h0301, 16'h0302, 16'h0303, 16'h0304, 16'h0305};
    model_packet();
    for (int i = 0; i < 3; i++) send_beat(i == 0, 1'b0, pkt[i], cyc);
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_clean: got %b want 0", proto_err); end
    send_beat(1'b1, 1'b0, pkt[3], cyc);
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_set: got %b want 1", proto_err); end
    send_beat(1'b0, 1'b1, pkt[4], cyc);
    pkt = '{16'h0400};
    model_packet();
    send_packet(-1);
    wait_drain();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky: got %b want 1", proto_err); end
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL proto_count: got %0d flits want 2", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL proto_flit %0d: got sop=%b eop=%b empty=%0d data=%h want sop=%b eop=%b empty=%0d data=%h", i,
                 got_q[i].sop, got_q[i].eop, got_q[i].empty, got_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].empty, exp_q[i].data);
      end
    end
  endtask

  task automatic test_random();
    exp_q.delete(); got_q.delete();
    pulse_reset();
    bp_rand = 1'b1;
    for (int p = 0; p < 8; p++) begin
      int len;
      len = $urandom_range(1, 40);
      pkt.delete();
      for (int i = 0; i < len; i++) pkt.push_back(16'($urandom));
      model_packet();
      send_packet(-1);
    end
    bp_rand = 1'b0;
    rdy_val = 1'b1;
    wait_drain();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count: got %0d flits want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL random_flit %0d: got sop=%b eop=%b empty=%0d data=%h want sop=%b eop=%b empty=%0d data=%h", i,
                 got_q[i].sop, got_q[i].eop, got_q[i].empty, got_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].empty, exp_q[i].data);
      end
    end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL random_proto_err: got %b want 0", proto_err); end
  endtask

`ifdef RULE_PKT_STATS_EN
  task automatic test_stats();
    int lens[3];
    lens = '{1, 16, 20};
    exp_q.delete(); got_q.delete();
    pulse_reset();
    for (int p = 0; p < 3; p++) begin
      pkt.delete();
      for (int i = 0; i < lens[p]; i++) pkt.push_back(16'($urandom));
      model_packet();
      send_packet(-1);
    end
    wait_drain();
    checks++; if (stat_pkt_cnt !== 32'd3) begin errors++; $display("FAIL stat_pkt_cnt: got %0d want 3", stat_pkt_cnt); end
    checks++; if (stat_rule_cnt !== 32'd37) begin errors++; $display("FAIL stat_rule_cnt: got %0d want 37", stat_rule_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_full_and_split();
    test_backpressure();
    test_reset_mid_packet();
    test_proto_err();
    test_random();
`ifdef RULE_PKT_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
